// File: rtl/serial_sub5_if.sv
// serial_sub5_if: start/busy/done handshake plus operand and result bundle for serial_sub5.
// Signals: start, X, Y (requester -> subtractor); busy, done, D, B5, Z (subtractor -> requester).
// With SERIAL_SUB_OVF_EN defined, the bundle also carries V (signed overflow).
interface serial_sub5_if #(parameter int WIDTH = 5);
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             B5;
  logic             Z;
`ifdef SERIAL_SUB_OVF_EN
  logic             V;
  modport master(output start, X, Y, input busy, done, D, B5, Z, V);
  modport slave(input start, X, Y, output busy, done, D, B5, Z, V);
`else
  modport master(output start, X, Y, input busy, done, D, B5, Z);
  modport slave(input start, X, Y, output busy, done, D, B5, Z);
`endif
endinterface

// File: rtl/serial_sub5.sv
// serial_sub5: bit-serial D = X - Y, LSB first, one full-subtractor cell and a borrow flop.
// Ports: clk, rst (sync, active-high); bus (slave modport): start, X, Y in; busy, done, D, B5, Z out.
// Optional macro SERIAL_SUB_OVF_EN adds V, the signed two's-complement overflow of the result.
module serial_sub5 #(
  parameter int WIDTH = 5,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          rst,
  serial_sub5_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] xs_q, ys_q, d_q, d_d;
  logic [CW-1:0]    cnt_q;
  logic             b_q, b_d, dbit, busy_q, done_q, b5_q, z_q;
  always_comb begin
    dbit = xs_q[0] ^ ys_q[0] ^ b_q;
    b_d  = (~xs_q[0] & ys_q[0]) | (~(xs_q[0] ^ ys_q[0]) & b_q);
    d_d  = {dbit, d_q[WIDTH-1:1]};
  end
`ifdef SERIAL_SUB_OVF_EN
  logic v_q;
  assign bus.V = v_q;
`endif
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.B5   = b5_q;
  assign bus.Z    = z_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      b5_q    <= 1'b0;
      z_q     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end else if (state_q == SHIFT) begin
      d_q   <= d_d;
      xs_q  <= xs_q >> 1;
      ys_q  <= ys_q >> 1;
      b_q   <= b_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        b5_q    <= b_d;
        z_q     <= ~|d_d;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        state_q <= DONE;
`ifdef SERIAL_SUB_OVF_EN
        // borrow into the MSB differs from borrow out of it
        v_q     <= b_q ^ b_d;
`endif
      end
    end else if (bus.start) begin
      // IDLE and DONE accept alike, so back-to-back operations need no idle cycle
      xs_q    <= bus.X;
      ys_q    <= bus.Y;
      d_q     <= '0;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      state_q <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
      v_q     <= 1'b0;
`endif
    end
  end
endmodule
